spi_slave_word_rx: RTL and testbench

- SPI mode-0 slave receiver. It is the far end of the 16-bit sample link driven by our SPI master toward the Arduino/consumer side.
- Oversamples SCLK, MOSI and CS_n in the i_Clk domain and assembles MSB-first words.
- Buffers received words in a small FIFO with a valid/ready output.
- Shifts a reply word out on MISO. Used in loopback benches and on a second FPGA acting as the link receiver.

---
 rtl/spi_slave_word_rx.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_word_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word_rx.sv
// SPI mode-0 slave receiver: oversamples SCLK/MOSI/CS_n, assembles MSB-first words
// into a small FIFO and shifts a reply word out on MISO.
module spi_slave_word_rx #(
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_MOSI,
  input  logic                  i_SPI_CS_n,
  output logic                  o_SPI_MISO,
  input  logic [WORD_WIDTH-1:0] i_TX_Word,
  output logic [WORD_WIDTH-1:0] o_RX_Word,
  output logic                  o_RX_DV,
  input  logic                  i_RX_Ready,
  output logic                  o_Overflow,
  output logic                  o_Frame_Err,
  input  logic                  i_Clr_Err,
  output logic                  o_Dbg_State
);

  localparam int CNT_W  = $clog2(WORD_WIDTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state_q, state_d;

  // Bit 1 is the synchronised level, bit 2 the delayed copy for edge detect.
  // MOSI needs no edge detect, so it is taken from its 2nd flop to stay aligned.
  logic [2:0] sclk_sr, cs_sr;
  logic [1:0] mosi_sr;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_sync;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sclk_sr <= 3'b000;
      cs_sr   <= 3'b111;
      mosi_sr <= 2'b00;
    end else begin
      sclk_sr <= {sclk_sr[1:0], i_SPI_Clk};
      cs_sr   <= {cs_sr[1:0], i_SPI_CS_n};
      mosi_sr <= {mosi_sr[0], i_SPI_MOSI};
    end
  end

  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign cs_fall   = ~cs_sr[1] & cs_sr[2];
  assign cs_rise   = cs_sr[1] & ~cs_sr[2];
  assign mosi_sync = mosi_sr[1];

  // A frame may only start after CS_n has been seen high on real pin samples,
  // so a CS_n held low across reset release never starts a frame.
  logic [1:0] fill_cnt;
  logic       armed;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      fill_cnt <= 2'd0;
      armed    <= 1'b0;
    end else begin
      if (fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
      if (fill_cnt == 2'd3 && cs_sr[1]) armed <= 1'b1;
    end
  end

  logic [CNT_W-1:0]      bit_cnt;
  logic [WORD_WIDTH-2:0] rx_shift;
  logic [WORD_WIDTH-1:0] tx_shift;
  logic [WORD_WIDTH-1:0] rx_next;
  logic load_tx, shift_tx, shift_rx, word_done, frame_err_set;

  assign rx_next = {rx_shift, mosi_sync};

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_tx       = 1'b0;
    shift_tx      = 1'b0;
    shift_rx      = 1'b0;
    word_done     = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed) begin
          state_d = ACTIVE;
          load_tx = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d       = IDLE;
          frame_err_set = (bit_cnt != '0);
        end else begin
          if (sclk_rise) begin
            shift_rx = 1'b1;
            if (bit_cnt == CNT_W'(WORD_WIDTH - 1)) begin
              word_done = 1'b1;
              load_tx   = 1'b1;
            end
          end
          // The falling edge right after a word boundary keeps the freshly
          // loaded MSB on MISO instead of shifting it away.
          if (sclk_fall && bit_cnt != '0) shift_tx = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else begin
      if (state_q == IDLE || cs_rise) bit_cnt <= '0;
      else if (shift_rx)              bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
      if (shift_rx) rx_shift <= rx_next[WORD_WIDTH-2:0];
      if (load_tx)       tx_shift <= i_TX_Word;
      else if (shift_tx) tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
    end
  end

  assign o_SPI_MISO  = (state_q == ACTIVE) ? tx_shift[WORD_WIDTH-1] : 1'b0;
  assign o_Dbg_State = (state_q == ACTIVE);

  // Output handshake: o_RX_Word is valid while o_RX_DV=1; a word is consumed on
  // every clock edge where o_RX_DV && i_RX_Ready. i_RX_Ready alone has no effect.
  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]     count;
  logic                  full, push, pop;

  assign full = (count == FCNT_W'(FIFO_DEPTH));
  assign pop  = i_RX_Ready && o_RX_DV;
  assign push = word_done && (!full || pop);

  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr] <= rx_next;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_RX_DV   = (count != '0);
  assign o_RX_Word = o_RX_DV ? mem[rd_ptr] : '0;

  // Sticky flags: a set event in the same cycle as i_Clr_Err wins.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Overflow  <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      if (word_done && full && !pop) o_Overflow <= 1'b1;
      else if (i_Clr_Err)            o_Overflow <= 1'b0;
      if (frame_err_set)             o_Frame_Err <= 1'b1;
      else if (i_Clr_Err)            o_Frame_Err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_word_rx.sv
// Directed bench for spi_slave_word_rx: SPI master model at 1 MHz SCLK against a
// 16 MHz system clock, with hand-computed expected words and flag states.
`timescale 1ns/1ps
module tb_spi_slave_word_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        miso;
  logic [15:0] tx_word = 16'h0000;
  logic [15:0] rx_word;
  logic        rx_dv;
  logic        rx_ready = 1'b0;
  logic        overflow;
  logic        frame_err;
  logic        clr_err = 1'b0;
  logic        dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  spi_slave_word_rx #(.WORD_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs_n),
    .o_SPI_MISO(miso), .i_TX_Word(tx_word), .o_RX_Word(rx_word), .o_RX_DV(rx_dv),
    .i_RX_Ready(rx_ready), .o_Overflow(overflow), .o_Frame_Err(frame_err),
    .i_Clr_Err(clr_err), .o_Dbg_State(dbg_state)
  );

  // 16 MHz system clock
  always #31.25 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SCLK period (8 clk low, 8 clk high); the master samples MISO at the rise.
  task automatic clock_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(8);
    m = miso;
    sclk = 1'b1;
    wait_clk(8);
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, output logic [15:0] r);
    logic m;
    for (int i = 15; i >= 0; i--) begin
      clock_bit(w[i], m);
      r[i] = m;
    end
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end();
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check({tag, "_dv"}, {31'd0, rx_dv}, 32'd1);
    check({tag, "_word"}, {16'd0, rx_word}, {16'd0, exp});
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic [15:0] w;
    logic        m;

    // Reset state
    rst = 1'b1;
    wait_clk(3);
    check("rst_dv", {31'd0, rx_dv}, 32'd0);
    check("rst_word", {16'd0, rx_word}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    wait_clk(8);

    // Single frame 0xA55A with receive latency measured from the 16th rise
    w = 16'hA55A;
    frame_begin();
    check("active_state", {31'd0, dbg_state}, 32'd1);
    for (int i = 15; i >= 1; i--) clock_bit(w[i], m);
    mosi = w[0];
    wait_clk(8);
    sclk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("lat_dv_edge2", {31'd0, rx_dv}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_dv_edge3", {31'd0, rx_dv}, 32'd1);
    check("lat_word_edge3", {16'd0, rx_word}, 32'h0000A55A);
    #4;
    wait_clk(5);
    sclk = 1'b0;
    frame_end();
    check("a55a_ovf", {31'd0, overflow}, 32'd0);
    check("a55a_ferr", {31'd0, frame_err}, 32'd0);
    pop_check("a55a", 16'hA55A);
    check("a55a_empty", {31'd0, rx_dv}, 32'd0);

    // Reply word on MISO
    tx_word = 16'h1234;
    check("idle_miso", {31'd0, miso}, 32'd0);
    frame_begin();
    send_word(16'h0F0F, r);
    frame_end();
    check("reply_single", {16'd0, r}, 32'h00001234);
    pop_check("rx_0f0f", 16'h0F0F);

    // Back-to-back words within one CS
    frame_begin();
    send_word(16'h0001, r);
    check("reply_b2b_1", {16'd0, r}, 32'h00001234);
    send_word(16'h8000, r);
    check("reply_b2b_2", {16'd0, r}, 32'h00001234);
    frame_end();
    pop_check("b2b_0001", 16'h0001);
    pop_check("b2b_8000", 16'h8000);
    check("b2b_empty", {31'd0, rx_dv}, 32'd0);

    // Overflow: five words with no consumer
    frame_begin();
    send_word(16'h1111, r);
    send_word(16'h2222, r);
    send_word(16'h3333, r);
    send_word(16'h4444, r);
    send_word(16'h5555, r);
    frame_end();
    check("ovf_set", {31'd0, overflow}, 32'd1);
    pop_check("ovf_1111", 16'h1111);
    pop_check("ovf_2222", 16'h2222);
    pop_check("ovf_3333", 16'h3333);
    pop_check("ovf_4444", 16'h4444);
    check("ovf_empty", {31'd0, rx_dv}, 32'd0);
    pulse_clr();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with the 5th push coinciding with a pop
    frame_begin();
    send_word(16'hA001, r);
    send_word(16'hA002, r);
    send_word(16'hA003, r);
    send_word(16'hA004, r);
    w = 16'hA005;
    for (int i = 15; i >= 1; i--) clock_bit(w[i], m);
    mosi = w[0];
    wait_clk(8);
    check("full_head", {16'd0, rx_word}, 32'h0000A001);
    sclk = 1'b1;
    repeat (2) @(posedge clk);
    #5;
    rx_ready = 1'b1;
    @(posedge clk);
    #5;
    rx_ready = 1'b0;
    wait_clk(5);
    sclk = 1'b0;
    frame_end();
    check("pushpop_ovf", {31'd0, overflow}, 32'd0);
    pop_check("pp_a002", 16'hA002);
    pop_check("pp_a003", 16'hA003);
    pop_check("pp_a004", 16'hA004);
    pop_check("pp_a005", 16'hA005);
    check("pp_empty", {31'd0, rx_dv}, 32'd0);

    // Frame error after 7 bits, then a clean frame
    frame_begin();
    for (int i = 0; i < 7; i++) clock_bit(1'b1, m);
    frame_end();
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_nopush", {31'd0, rx_dv}, 32'd0);
    frame_begin();
    send_word(16'hBEEF, r);
    frame_end();
    pop_check("beef", 16'hBEEF);
    check("ferr_sticky", {31'd0, frame_err}, 32'd1);

    // Reset mid-frame with two words buffered
    frame_begin();
    send_word(16'h1357, r);
    send_word(16'h2468, r);
    frame_end();
    check("pre_rst_dv", {31'd0, rx_dv}, 32'd1);
    frame_begin();
    for (int i = 0; i < 9; i++) clock_bit(1'b1, m);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    check("mrst_dv", {31'd0, rx_dv}, 32'd0);
    check("mrst_word", {16'd0, rx_word}, 32'd0);
    check("mrst_miso", {31'd0, miso}, 32'd0);
    check("mrst_ovf", {31'd0, overflow}, 32'd0);
    check("mrst_ferr", {31'd0, frame_err}, 32'd0);
    for (int i = 0; i < 7; i++) clock_bit(1'b0, m);
    frame_end();
    check("mrst_nopush", {31'd0, rx_dv}, 32'd0);
    check("mrst_noferr", {31'd0, frame_err}, 32'd0);
    frame_begin();
    send_word(16'h7E81, r);
    frame_end();
    pop_check("post_rst_7e81", 16'h7E81);
    check("final_empty", {31'd0, rx_dv}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
